// File: rtl/spi_display_pkg.sv
// Shared types and constants for the SPI display-interface word receiver.
package spi_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WORD_LEN_DEF = 18;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_display_rx_if.sv
// Serial line inputs and received-word outputs of the SPI display receiver.
interface spi_display_rx_if
    import spi_display_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
);
    logic                CSX;
    logic                SCL;
    logic                SDA;
    logic                DCX;
    logic [WORD_LEN-1:0] word;
    logic                word_dc;
    logic                word_valid;
    logic                busy;
    logic                abort_err;

    modport master (
        output CSX, SCL, SDA, DCX,
        input  word, word_dc, word_valid, busy, abort_err
    );

    modport slave (
        input  CSX, SCL, SDA, DCX,
        output word, word_dc, word_valid, busy, abort_err
    );
endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for one asynchronous line; rst_val is the idle level of the line.
module spi_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic rst_val,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous line
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_r <= rst_val;
            sync_r <= rst_val;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/spi_display_rx.sv
// Receives fixed-length serial words framed by CSX, sampling SDA on SCL rising edges
// detected in the CLK domain; reports completed words and mid-word aborts.
module spi_display_rx
    import spi_display_pkg::*;
#(
    parameter int WORD_LEN  = WORD_LEN_DEF,
    parameter int LSB_FIRST = 1
) (
    input logic             CLK,
    input logic             RST,
    spi_display_rx_if.slave bus
);
    localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    logic csx_s;
    logic scl_s;
    logic sda_s;
    logic dcx_s;

    spi_sync2 u_sync_csx (.CLK(CLK), .RST(RST), .rst_val(1'b1),    .d(bus.CSX), .q(csx_s));
    spi_sync2 u_sync_scl (.CLK(CLK), .RST(RST), .rst_val(1'b0),    .d(bus.SCL), .q(scl_s));
    spi_sync2 u_sync_sda (.CLK(CLK), .RST(RST), .rst_val(1'b0),    .d(bus.SDA), .q(sda_s));
    spi_sync2 u_sync_dcx (.CLK(CLK), .RST(RST), .rst_val(DC_DATA), .d(bus.DCX), .q(dcx_s));

    state_e              state_r;
    state_e              state_next_s;
    logic                scl_prev_r;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_next_s;
    logic [WORD_LEN-1:0] shreg_r;
    logic [WORD_LEN-1:0] shreg_next_s;
    logic [WORD_LEN-1:0] asm_s;
    logic                dc_r;
    logic                dc_next_s;
    logic                dc_load_s;
    logic                load_s;
    logic                abort_s;
    logic                last_s;
    logic                rise_s;
    logic                qual_s;
    logic [WORD_LEN-1:0] word_r;
    logic                word_dc_r;
    logic                word_valid_r;
    logic                abort_err_r;

    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] cnt);
        if (LSB_FIRST != 0) begin
            return cnt;
        end else begin
            return CW'(WORD_LEN - 1) - cnt;
        end
    endfunction

    // Previous SCL resets high so a line already high at reset release is not a rise
    assign rise_s = scl_s & ~scl_prev_r;
    assign qual_s = rise_s & ~csx_s;
    assign last_s = (cnt_r == CW'(WORD_LEN - 1));

    // Next-state, shift and completion decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        shreg_next_s = shreg_r;
        dc_next_s    = dc_r;
        dc_load_s    = dc_r;
        load_s       = 1'b0;
        abort_s      = 1'b0;
        if (state_r == SHIFT) begin
            asm_s = shreg_r;
        end else begin
            asm_s = '0;
        end
        asm_s[bit_pos(cnt_r)] = sda_s;

        case (state_r)
            IDLE: begin
                if (qual_s) begin
                    dc_next_s = dcx_s;
                    dc_load_s = dcx_s;
                    if (last_s) begin
                        load_s       = 1'b1;
                        cnt_next_s   = '0;
                        shreg_next_s = '0;
                    end else begin
                        shreg_next_s = asm_s;
                        cnt_next_s   = cnt_r + CW'(1);
                        state_next_s = SHIFT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                // CSX high wins over a coincident SCL rise
                if (csx_s) begin
                    abort_s      = 1'b1;
                    cnt_next_s   = '0;
                    shreg_next_s = '0;
                    state_next_s = IDLE;
                end else if (qual_s) begin
                    if (last_s) begin
                        load_s       = 1'b1;
                        cnt_next_s   = '0;
                        shreg_next_s = '0;
                        state_next_s = IDLE;
                    end else begin
                        shreg_next_s = asm_s;
                        cnt_next_s   = cnt_r + CW'(1);
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                cnt_next_s   = '0;
                shreg_next_s = '0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bit counter, shift register, captured DCX and SCL history
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_prev_r <= 1'b1;
            cnt_r      <= '0;
            shreg_r    <= '0;
            dc_r       <= DC_CMD;
        end else begin
            scl_prev_r <= scl_s;
            cnt_r      <= cnt_next_s;
            shreg_r    <= shreg_next_s;
            dc_r       <= dc_next_s;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_r       <= '0;
            word_dc_r    <= DC_CMD;
            word_valid_r <= 1'b0;
            abort_err_r  <= 1'b0;
        end else begin
            word_valid_r <= load_s;
            abort_err_r  <= abort_s;
            if (load_s) begin
                word_r    <= asm_s;
                word_dc_r <= dc_load_s;
            end
        end
    end

    assign bus.word       = word_r;
    assign bus.word_dc    = word_dc_r;
    assign bus.word_valid = word_valid_r;
    assign bus.abort_err  = abort_err_r;
    assign bus.busy       = (state_r == SHIFT);
endmodule

// File: tb/tb_spi_display_rx.sv
// Bench for spi_display_rx: LSB-first and MSB-first instances share one serial stream,
// a queue-based scoreboard compares every completed word against a reference model.
module tb_spi_display_rx;
    import spi_display_pkg::*;

    localparam int WL = 18;

    logic CLK = 1'b0;
    logic RST;
    logic csx;
    logic scl;
    logic sda;
    logic dcx;

    always #5 CLK = ~CLK;

    spi_display_rx_if #(.WORD_LEN(WL)) bus_l ();
    spi_display_rx_if #(.WORD_LEN(WL)) bus_m ();

    assign bus_l.CSX = csx;
    assign bus_l.SCL = scl;
    assign bus_l.SDA = sda;
    assign bus_l.DCX = dcx;
    assign bus_m.CSX = csx;
    assign bus_m.SCL = scl;
    assign bus_m.SDA = sda;
    assign bus_m.DCX = dcx;

    spi_display_rx #(.WORD_LEN(WL), .LSB_FIRST(1)) dut_l (.CLK(CLK), .RST(RST), .bus(bus_l));
    spi_display_rx #(.WORD_LEN(WL), .LSB_FIRST(0)) dut_m (.CLK(CLK), .RST(RST), .bus(bus_m));

    typedef struct packed {
        logic [WL-1:0] w;
        logic          dc;
    } exp_t;

    exp_t q_l[$];
    exp_t q_m[$];
    int checks  = 0;
    int passes  = 0;
    int vld_l   = 0;
    int vld_m   = 0;
    int ab_l    = 0;
    int ab_m    = 0;
    int exp_vld = 0;
    int exp_ab  = 0;
    logic [WL-1:0] last_l = '0;
    logic [WL-1:0] last_m = '0;

    // Serial bit i lands at weight 2^i (LSB first) or 2^(WL-1-i) (MSB first)
    function automatic logic [WL-1:0] ref_word(input logic [WL-1:0] s, input bit msb_first);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < WL; i++) begin
            if (s[i]) begin
                v = v | (32'd1 << (msb_first ? (WL - 1 - i) : i));
            end
        end
        return v[WL-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [WL-1:0] s, input int nbits, input logic dc);
        for (int i = 0; i < nbits; i++) begin
            sda = s[i];
            dcx = dc;
            tick(4);
            scl = 1'b1;
            tick(4);
            scl = 1'b0;
        end
    endtask

    task automatic send_word(input logic [WL-1:0] s, input logic dc);
        q_l.push_back({ref_word(s, 1'b0), dc});
        q_m.push_back({ref_word(s, 1'b1), dc});
        exp_vld++;
        send_bits(s, WL, dc);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_word_l"},  32'(bus_l.word), 32'd0);
        chk({tag, "_word_m"},  32'(bus_m.word), 32'd0);
        chk({tag, "_dc_l"},    32'(bus_l.word_dc), 32'd0);
        chk({tag, "_valid_l"}, 32'(bus_l.word_valid), 32'd0);
        chk({tag, "_busy_l"},  32'(bus_l.busy), 32'd0);
        chk({tag, "_busy_m"},  32'(bus_m.busy), 32'd0);
        chk({tag, "_abort_l"}, 32'(bus_l.abort_err), 32'd0);
    endtask

    // Monitor, LSB-first instance
    always @(negedge CLK) begin
        exp_t e;
        if (bus_l.abort_err === 1'b1) ab_l++;
        if (bus_l.word_valid === 1'b1) begin
            vld_l++;
            chk("lsb_queue_nonempty", 32'(q_l.size() > 0), 32'd1);
            if (q_l.size() > 0) begin
                e = q_l.pop_front();
                chk("lsb_word", 32'(bus_l.word), 32'(e.w));
                chk("lsb_dc", 32'(bus_l.word_dc), 32'(e.dc));
                last_l = e.w;
            end
        end
    end

    // Monitor, MSB-first instance
    always @(negedge CLK) begin
        exp_t e;
        if (bus_m.abort_err === 1'b1) ab_m++;
        if (bus_m.word_valid === 1'b1) begin
            vld_m++;
            chk("msb_queue_nonempty", 32'(q_m.size() > 0), 32'd1);
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                chk("msb_word", 32'(bus_m.word), 32'(e.w));
                chk("msb_dc", 32'(bus_m.word_dc), 32'(e.dc));
                last_m = e.w;
            end
        end
    end

    initial begin
        logic [WL-1:0] r;
        int            sel;
        int            nb;

        RST = 1'b1;
        csx = 1'b1;
        scl = 1'b0;
        sda = 1'b0;
        dcx = 1'b1;
        tick(3);
        chk_zero_outputs("reset");
        RST = 1'b0;
        tick(4);

        // Single LSB-first word
        csx = 1'b0;
        tick(4);
        send_word(18'b100000111000110001, 1'b1);
        tick(8);
        chk("w1_valid_count", 32'(vld_l), 32'd1);
        chk("w1_word_l", 32'(bus_l.word), 32'h20E31);
        chk("w1_dc_l", 32'(bus_l.word_dc), 32'd1);
        chk("w1_no_abort", 32'(ab_l), 32'd0);

        // Back-to-back words in one frame; second one is the MSB-first boundary pattern
        send_word(18'h3FFFF, 1'b0);
        send_word(18'h00001, 1'b1);
        tick(8);
        chk("b2b_valid_count", 32'(vld_l), 32'd3);
        chk("msb_single_one", 32'(bus_m.word), 32'h20000);

        // CSX rise at a word boundary is not an error
        csx = 1'b1;
        tick(8);
        chk("boundary_no_abort_l", 32'(ab_l), 32'd0);
        chk("boundary_no_abort_m", 32'(ab_m), 32'd0);

        // Abort after 7 bits
        csx = 1'b0;
        tick(4);
        r = WL'($urandom);
        send_bits(r, 7, 1'b1);
        chk("abort_busy_before", 32'(bus_l.busy), 32'd1);
        csx = 1'b1;
        exp_ab++;
        tick(6);
        chk("abort_count_l", 32'(ab_l), 32'(exp_ab));
        chk("abort_count_m", 32'(ab_m), 32'(exp_ab));
        chk("abort_no_valid", 32'(vld_l), 32'(exp_vld));
        chk("abort_busy_after", 32'(bus_l.busy), 32'd0);
        chk("abort_word_held_l", 32'(bus_l.word), 32'(ref_word(18'h00001, 1'b0)));
        chk("abort_word_held_m", 32'(bus_m.word), 32'(ref_word(18'h00001, 1'b1)));
        csx = 1'b0;
        tick(4);
        send_word(WL'($urandom), 1'b0);
        tick(8);

        // Reset mid-word
        send_bits(WL'($urandom), 10, 1'b0);
        chk("rst_busy_before", 32'(bus_l.busy), 32'd1);
        RST = 1'b1;
        tick(1);
        chk_zero_outputs("midreset");
        RST = 1'b0;
        tick(4);
        chk("rst_no_abort", 32'(ab_l), 32'(exp_ab));
        send_word(18'h15555, 1'b1);
        tick(8);
        chk("post_rst_word_l", 32'(bus_l.word), 32'h15555);

        // SCL rise coincident with CSX rise on the final bit
        r = WL'($urandom);
        send_bits(r, 17, 1'b1);
        sda = r[17];
        tick(4);
        scl = 1'b1;
        csx = 1'b1;
        exp_ab++;
        tick(6);
        scl = 1'b0;
        chk("coinc_abort", 32'(ab_l), 32'(exp_ab));
        chk("coinc_no_valid", 32'(vld_l), 32'(exp_vld));
        tick(4);

        // Randomized frames: full words, aborts and frame breaks
        for (int k = 0; k < 16; k++) begin
            csx = 1'b0;
            tick($urandom_range(2, 5));
            sel = $urandom_range(0, 3);
            r   = WL'($urandom);
            if (sel == 0) begin
                nb = $urandom_range(1, 17);
                send_bits(r, nb, 1'($urandom));
                csx = 1'b1;
                exp_ab++;
                tick(6);
            end else begin
                send_word(r, 1'($urandom));
                if (sel == 1) begin
                    tick(6);
                    csx = 1'b1;
                    tick(6);
                end
            end
        end
        csx = 1'b1;
        tick(20);

        chk("final_queue_l", 32'(q_l.size()), 32'd0);
        chk("final_queue_m", 32'(q_m.size()), 32'd0);
        chk("final_valid_l", 32'(vld_l), 32'(exp_vld));
        chk("final_valid_m", 32'(vld_m), 32'(exp_vld));
        chk("final_abort_l", 32'(ab_l), 32'(exp_ab));
        chk("final_abort_m", 32'(ab_m), 32'(exp_ab));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spi_display_rx.md
SPI_DISPLAY_RX -- requirements
Module: spi_display_rx

Interface
REQ-001 Parameter WORD_LEN, default 18: bits per received word.
REQ-002 Parameter LSB_FIRST, default 1: 1 means the first serial bit is bit 0; 0 means the first serial bit is bit WORD_LEN-1.
REQ-003 CLK  input  1: single clock for all logic; rising-edge only.
REQ-004 RST  input  1: reset, synchronous, active-high.
REQ-005 CSX  input  1: chip select, active low, asynchronous to CLK.
REQ-006 SCL  input  1: serial clock, asynchronous; data is valid on its rising edge.
REQ-007 SDA  input  1: serial data, asynchronous.
REQ-008 DCX  input  1: 1 means data, 0 means command; asynchronous.
REQ-009 word  output  WORD_LEN: last completed word; held until the next completion.
REQ-010 word_dc  output  1: DCX value captured for `word`.
REQ-011 word_valid  output  1: one-CLK pulse when `word` and `word_dc` update.
REQ-012 busy  output  1: high while a word is partially shifted.
REQ-013 abort_err  output  1: one-CLK pulse when CSX deasserts mid-word.

Function
REQ-014 CSX, SCL, SDA and DCX shall each pass through a two-flop synchronizer before any use.
REQ-015 The SCL rising edge shall be detected as "synchronized SCL = 1 and its previous registered value = 0".
REQ-016 Correct operation requires the SCL high time and low time each to be at least 2 CLK periods, with SDA/DCX stable for at least 3 CLK periods around the SCL rise.
  - Faster SCL is outside the operating range.
  - The block need not detect faster SCL.
REQ-017 Unit state machine states: IDLE, SHIFT.
REQ-018 IDLE -> SHIFT on the first qualified SCL rise while synchronized CSX = 0; that SDA bit becomes bit 1 of the word.
REQ-019 Qualified edge: an SCL rise in a cycle where synchronized CSX = 0; an SCL rise in the same cycle as a synchronized CSX = 1 shall be ignored.
REQ-020 Bit counter range is 0..WORD_LEN-1; bit position is the count if LSB_FIRST = 1, else WORD_LEN-1-count.
REQ-021 DCX shall be captured on the first bit of each word.
REQ-022 Word completion: on the qualified edge carrying bit WORD_LEN, the block shall:
  - assemble the word;
  - update `word`/`word_dc` and pulse `word_valid` in the next CLK cycle (one cycle after the edge is detected);
  - clear the counter;
  - return to IDLE.
REQ-023 Back-to-back words within one CSX-low frame shall be received without gaps or lost bits.
REQ-024 While in SHIFT, synchronized CSX = 1 shall:
  - discard the partial word;
  - pulse `abort_err` for 1 cycle;
  - clear the counter;
  - enter IDLE;
  - leave `word` unchanged.
REQ-025 CSX rising in IDLE (a word boundary) shall produce no error.
REQ-026 `busy` = 1 exactly while in SHIFT.

Reset
REQ-027 With RST high at a CLK edge, the following shall be 0 on the next cycle:
  - state = IDLE;
  - counter;
  - shift register;
  - word;
  - word_dc;
  - word_valid;
  - busy;
  - abort_err.
REQ-028 Synchronizer flops shall reset to idle line levels: CSX = 1, SCL = 0, SDA = 0, DCX = 1.
REQ-029 Reset asserted mid-word shall drop the partial word without pulsing `abort_err`.
REQ-030 The first SCL rise detected after reset release shall only count if SCL was previously seen low post-reset.

Structure
REQ-031 Shared package spi_display_pkg shall hold:
  - the state enumeration (IDLE, SHIFT);
  - the WORD_LEN default constant 18;
  - the DCX encoding constants (DC_CMD = 0, DC_DATA = 1).
REQ-032 A single sub-module spi_sync2 (a parameterless two-flop synchronizer with a reset value input) shall be instantiated once per input line.
REQ-033 All other logic shall reside in spi_display_rx.

Verification
REQ-034 One 18-bit word, LSB-first:
  - stimulus: CSX low, DCX = 1, SCL half-period 4 CLK, bits of 18'b100000111000110001 sent bit 0 first;
  - response: word = 18'h20E31, word_dc = 1, exactly one word_valid pulse, abort_err never pulses.
REQ-035 Two back-to-back words in one frame:
  - stimulus: 18'h3FFFF with DCX = 0, then 18'h00001 with DCX = 1;
  - response: two word_valid pulses, with (word, word_dc) = (3FFFF, 0) then (00001, 1).
REQ-036 Mid-word abort:
  - stimulus: CSX raised after 7 bits;
  - response: one abort_err pulse, no word_valid, word keeps its prior value, busy falls;
  - follow-up: the next full word is received correctly.
REQ-037 Reset mid-word:
  - stimulus: RST held 1 cycle after 10 bits;
  - response: all outputs are 0, there is no abort_err, and the subsequent 18-bit word 18'h15555 is received correctly.
REQ-038 MSB-first ordering:
  - stimulus: LSB_FIRST = 0, with the serial stream 1 followed by seventeen 0s;
  - response: word = 18'h20000.
REQ-039 Edge coincident with CSX rise:
  - stimulus: an SCL rise in the same synchronized cycle as the CSX rise, at bit 18;
  - response: the edge is ignored, abort_err pulses, and there is no word_valid.
